// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between the CPU datapath and an external loader port.
// Optional feature: define MEM_ARB_EXT_LOCK_EN to let ext_lock pin the grant on the external port.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    input  logic              ext_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_ext
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           state;
    logic             last_ext;
    logic             acc_we;
    logic [CNT_W-1:0] cnt;
    logic             lock_win;
    logic             ext_win;

`ifdef MEM_ARB_EXT_LOCK_EN
    assign lock_win = ext_lock & ext_req;
`else
    logic unused_ext_lock;
    assign unused_ext_lock = ext_lock;
    assign lock_win        = 1'b0;
`endif

    // Round-robin: external wins when alone, when the CPU had the last grant, or under lock.
    assign ext_win   = lock_win | (ext_req & (~cpu_req | ~last_ext));

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            last_ext  <= 1'b1;
            acc_we    <= 1'b0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
            cpu_ack   <= 1'b0;
            ext_ack   <= 1'b0;
            grant_ext <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    grant_ext <= 1'b0;
                    if (cpu_req || ext_req) begin
                        grant_ext <= ext_win;
                        last_ext  <= ext_win;
                        acc_we    <= ext_win ? ext_we : cpu_we;
                        mem_en    <= 1'b1;
                        mem_we    <= ext_win ? ext_we : cpu_we;
                        mem_addr  <= ext_win ? ext_addr : cpu_addr;
                        mem_wdata <= ext_win ? ext_wdata : cpu_wdata;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    cnt    <= CNT_W'(WAIT_CYCLES);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    // Counter reaching zero this edge: read data is valid on mem_rdata now.
                    if (cnt == CNT_W'(1)) begin
                        if (!acc_we) begin
                            if (grant_ext) ext_rdata <= mem_rdata;
                            else           cpu_rdata <= mem_rdata;
                        end
                        cpu_ack <= ~grant_ext;
                        ext_ack <= grant_ext;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    cpu_ack   <= 1'b0;
                    ext_ack   <= 1'b0;
                    grant_ext <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-ported unified instruction/data memory between two requesters:
  - the multicycle CPU datapath (fetch/load/store accesses driven by the control unit's MemRead/MemWrite/IorD path);
  - an external port used by the program loader / debug host.
- Sequences each access through a fixed-latency memory.
- Returns read data to the winning requester with a one-cycle ack.
- Drives a stall signal that the top level inverts into the control unit's Enable.

## Interface

- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, memory read latency in cycles after the mem_en cycle; legal range 1..15.

- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req is high.
- cpu_rdata  out  DATA_W  registered read data; valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  combinational: cpu_req & ~cpu_ack.
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external port; same rules as the CPU port.
- ext_rdata  out  DATA_W  external read data.
- ext_ack  out  1  external completion pulse.
- ext_lock  in  1  keeps the grant on the external port (see Configuration).
- mem_en  out  1  memory access strobe; one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid WAIT_CYCLES cycles after mem_en.
- grant_ext  out  1  1 while the external port owns the access in flight.

## Operation

- FSM states:
  - IDLE: sample cpu_req/ext_req.
    - If any request is present, latch the winner's we/addr/wdata.
    - Set grant_ext and go to ACCESS.
  - ACCESS: mem_en=1 for exactly one cycle with the latched we/addr/wdata.
    - Load the wait counter with WAIT_CYCLES.
    - Go to WAIT.
  - WAIT: decrement the counter each cycle.
    - When it reaches 0 on a read, capture mem_rdata into the winner's rdata register.
    - Assert the winner's ack; go to RESP.
  - RESP: ack is high this cycle only.
    - Requests are ignored.
    - Go to IDLE.
- Arbitration in IDLE:
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins (round-robin).
  - last_grant resets to EXT, so the CPU wins the first contended access.
- Writes follow the same sequence:
  - the rdata registers are not updated;
  - ack is still pulsed.
- The losing requester keeps its req high and is served next. The rule guarantees no starvation.
- A request that drops before its ack is a protocol violation; behaviour is undefined (not checked).

## Timing

- Reset (Reset_n=0), immediate and asynchronous:
  - outputs: mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, ext_rdata, cpu_ack, ext_ack, grant_ext all go to 0;
  - internal state: state=IDLE, last_grant=EXT, counter=0.
- Reset mid-access: the in-flight access is abandoned and no ack is issued. The memory may have already performed a write.
- Latency: with req sampled at edge E0, the sequence is:
  - mem_en high in cycle E0..E1;
  - rdata latched and ack high in cycle E(1+WAIT_CYCLES)..E(2+WAIT_CYCLES).
  - Total from request sample to ack = WAIT_CYCLES+1 cycles.
- Throughput: one access per WAIT_CYCLES+3 cycles. A request still high during RESP is not re-sampled.
- cpu_stall is combinational, so the CPU is frozen during the same cycle its request is raised. It deasserts in the ack cycle.
- Simultaneous arrival of both requests in IDLE: resolved by last_grant. The loser waits one full access.
- The wait counter is 4 bits. WAIT_CYCLES=1 means mem_rdata is sampled at the first edge after the mem_en cycle.

## Configuration

- MEM_ARB_EXT_LOCK_EN defined:
  - in IDLE with ext_lock=1 and ext_req=1, the external port wins regardless of cpu_req and last_grant;
  - used for bulk program load while the CPU is held stalled.
- MEM_ARB_EXT_LOCK_EN undefined:
  - the ext_lock port exists but is ignored;
  - pure round-robin only.

## Test plan

- Reset then CPU read of addr 0x10 (memory holds 0xDEADBEEF), WAIT_CYCLES=1:
  - mem_en high one cycle with addr 0x10;
  - cpu_ack 2 cycles after sampling, cpu_rdata=0xDEADBEEF;
  - cpu_stall high until the ack cycle.
- Ext write 0x12345678 to 0x20, then CPU read of 0x20:
  - mem_we=1 on the first mem_en;
  - ext_ack pulses and ext_rdata stays unchanged;
  - CPU reads 0x12345678.
- cpu_req and ext_req raised in the same cycle after reset:
  - the CPU is served first, then the external port;
  - with both held continuously, grants alternate CPU, EXT, CPU, EXT.
- With MEM_ARB_EXT_LOCK_EN, ext_lock=1 and both requesting continuously:
  - 4 consecutive external grants and zero cpu_ack;
  - after ext_lock drops, the CPU is granted next.
- Reset_n pulsed low during WAIT of a CPU read:
  - all outputs 0 immediately, no cpu_ack;
  - after release, a held cpu_req is re-served with correct data.
- WAIT_CYCLES=3: ack arrives 4 cycles after sampling, and the next access issues no earlier than 6 cycles after the previous mem_en.
